// File: rtl/fifo_rd_serializer.sv
// rtl/fifo_rd_serializer.sv - FIFO read-side drain: pops words, emits OUT_WIDTH slices on a valid/ready stream (optional FIFO_RD_SER_PARITY_EN adds m_parity)
module fifo_rd_serializer #(
   parameter int FIFO_WIDTH = 16,
   parameter int OUT_WIDTH  = 8,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   input  logic [FIFO_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_en,
   output logic [OUT_WIDTH-1:0]  m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic [15:0]           word_cnt,
   output logic                  busy
`ifdef FIFO_RD_SER_PARITY_EN
   ,
   output logic                  m_parity
`endif
);

   localparam int RATIO = FIFO_WIDTH / OUT_WIDTH;
   localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [FIFO_WIDTH-1:0]   sreg_q, sreg_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [OUT_WIDTH-1:0]    m_data_q, m_data_d;
   logic                    m_valid_q, m_valid_d;
   logic                    m_last_q, m_last_d;
   logic [15:0]             word_cnt_q, word_cnt_d;
   logic [FIFO_WIDTH-1:0]   shifted;
   logic                    accept;
   logic                    accept_last;
`ifdef FIFO_RD_SER_PARITY_EN
   logic                    parity_q, parity_d;
`endif

   // Slice that leads the word, depending on emission order.
   function automatic logic [OUT_WIDTH-1:0] lead_slice(input logic [FIFO_WIDTH-1:0] w);
      if (MSB_FIRST) begin
         return w[FIFO_WIDTH-1 -: OUT_WIDTH];
      end
      return w[OUT_WIDTH-1:0];
   endfunction

   assign accept      = m_valid_q && m_ready;
   assign accept_last = accept && m_last_q;
   // A read is only issued when no word is held, so at most one read is ever outstanding.
   assign fifo_rd_en  = !fifo_empty && ((state_q == IDLE) || ((state_q == SEND) && accept_last));
   assign shifted     = MSB_FIRST ? (sreg_q << OUT_WIDTH) : (sreg_q >> OUT_WIDTH);

   assign m_data   = m_data_q;
   assign m_valid  = m_valid_q;
   assign m_last   = m_last_q;
   assign word_cnt = word_cnt_q;
   assign busy     = (state_q != IDLE);
`ifdef FIFO_RD_SER_PARITY_EN
   assign m_parity = parity_q;
`endif

   // Next-state and registered-output logic for the drain FSM.
   always_comb begin
      state_d    = state_q;
      sreg_d     = sreg_q;
      cnt_d      = cnt_q;
      m_data_d   = m_data_q;
      m_valid_d  = m_valid_q;
      m_last_d   = m_last_q;
      word_cnt_d = word_cnt_q;
      case (state_q)
         IDLE: begin
            if (fifo_rd_en) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            // FIFO data is valid now; the first slice goes out next cycle.
            sreg_d    = fifo_data;
            cnt_d     = '0;
            m_data_d  = lead_slice(fifo_data);
            m_valid_d = 1'b1;
            m_last_d  = (LAST_CNT == '0);
            state_d   = SEND;
         end
         SEND: begin
            if (accept) begin
               if (m_last_q) begin
                  word_cnt_d = word_cnt_q + 16'd1;
                  m_valid_d  = 1'b0;
                  m_last_d   = 1'b0;
                  state_d    = fifo_rd_en ? FETCH : IDLE;
               end else begin
                  sreg_d   = shifted;
                  cnt_d    = cnt_q + 1'b1;
                  m_data_d = lead_slice(shifted);
                  m_last_d = ((cnt_q + 1'b1) == LAST_CNT);
               end
            end
         end
         default: begin
            state_d   = IDLE;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
         end
      endcase
   end

`ifdef FIFO_RD_SER_PARITY_EN
   // Parity tracks the slice being registered so it stays aligned with m_data.
   always_comb begin
      parity_d = ^m_data_d;
   end
`endif

   // State and output registers; async reset discards any partial word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sreg_q     <= '0;
         cnt_q      <= '0;
         m_data_q   <= '0;
         m_valid_q  <= 1'b0;
         m_last_q   <= 1'b0;
         word_cnt_q <= '0;
`ifdef FIFO_RD_SER_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         sreg_q     <= sreg_d;
         cnt_q      <= cnt_d;
         m_data_q   <= m_data_d;
         m_valid_q  <= m_valid_d;
         m_last_q   <= m_last_d;
         word_cnt_q <= word_cnt_d;
`ifdef FIFO_RD_SER_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// tb/tb_fifo_rd_serializer.sv - directed table-driven bench for fifo_rd_serializer
module tb_fifo_rd_serializer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fifo_empty;
   logic [15:0] fifo_data;
   logic        fifo_rd_en;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_last;
   logic [15:0] word_cnt;
   logic        busy;

   logic        fifo_empty2;
   logic [15:0] fifo_data2;
   logic        fifo_rd_en2;
   logic [7:0]  m_data2;
   logic        m_valid2;
   logic        m_last2;
   logic [15:0] word_cnt2;
   logic        busy2;
`ifdef FIFO_RD_SER_PARITY_EN
   logic        m_parity;
   logic        m_parity2;
`endif

   always #5 clk = ~clk;

   fifo_rd_serializer #(.FIFO_WIDTH(16), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .m_last(m_last), .word_cnt(word_cnt), .busy(busy)
`ifdef FIFO_RD_SER_PARITY_EN
      , .m_parity(m_parity)
`endif
   );

   fifo_rd_serializer #(.FIFO_WIDTH(16), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty2), .fifo_data(fifo_data2),
      .fifo_rd_en(fifo_rd_en2), .m_data(m_data2), .m_valid(m_valid2), .m_ready(1'b1),
      .m_last(m_last2), .word_cnt(word_cnt2), .busy(busy2)
`ifdef FIFO_RD_SER_PARITY_EN
      , .m_parity(m_parity2)
`endif
   );

   assign fifo_data2 = 16'hA55A;

   // Sync FIFO model with one-cycle read latency.
   logic [15:0] mem [0:31];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   assign fifo_empty = (rd_ptr == wr_ptr);
   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_data <= mem[rd_ptr % 32];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   int n_tests = 0;
   int n_fail  = 0;
   int exp_wc  = 0;

   logic [7:0] got_data [0:15];
   logic       got_last [0:15];
   logic       got_par  [0:15];
   int         got_cyc  [0:15];
   int         got_n;
   int         rd_pulses;

   typedef struct {
      logic [15:0] word;
      logic [7:0]  s0;
      logic [7:0]  s1;
   } vec_t;
   vec_t vecs [0:4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [15:0] w);
      mem[wr_ptr % 32] = w;
      wr_ptr++;
   endtask

   // Called at a negedge; records accepted slices until n are seen or the budget expires.
   task automatic collect(input int n, input int budget);
      got_n     = 0;
      rd_pulses = 0;
      for (int cyc = 0; cyc < budget; cyc++) begin
         #1;
         if (fifo_rd_en) rd_pulses++;
         if (m_valid && m_ready && got_n < 16) begin
            got_data[got_n] = m_data;
            got_last[got_n] = m_last;
`ifdef FIFO_RD_SER_PARITY_EN
            got_par[got_n]  = m_parity;
`else
            got_par[got_n]  = 1'b0;
`endif
            got_cyc[got_n]  = cyc;
            got_n++;
         end
         if (got_n >= n) break;
         @(negedge clk);
      end
      if (got_n < n) check("collect_timeout", got_n, n);
   endtask

   initial begin
      vecs[0] = '{16'hA55A, 8'hA5, 8'h5A};
      vecs[1] = '{16'h0000, 8'h00, 8'h00};
      vecs[2] = '{16'hFFFF, 8'hFF, 8'hFF};
      vecs[3] = '{16'h8001, 8'h80, 8'h01};
      vecs[4] = '{16'h0703, 8'h07, 8'h03};

      // 1. reset state
      rst_n       = 1'b0;
      m_ready     = 1'b0;
      fifo_empty2 = 1'b1;
      @(negedge clk); #1;
      check("rst_valid", m_valid, 0);
      check("rst_data", m_data, 8'h00);
      check("rst_last", m_last, 0);
      check("rst_wcnt", word_cnt, 0);
      check("rst_busy", busy, 0);
      check("rst_rden", fifo_rd_en, 0);
      check("rst_rden2", fifo_rd_en2, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // 2. single word, exact latency
      @(negedge clk);
      m_ready = 1'b1;
      push(16'hA55A);
      #1;
      check("t2_rden", fifo_rd_en, 1);
      check("t2_busy0", busy, 0);
      @(negedge clk); #1;
      check("t2_fetch_rden", fifo_rd_en, 0);
      check("t2_fetch_valid", m_valid, 0);
      check("t2_fetch_busy", busy, 1);
      @(negedge clk); #1;
      check("t2_s0_valid", m_valid, 1);
      check("t2_s0_data", m_data, 8'hA5);
      check("t2_s0_last", m_last, 0);
      check("t2_s0_rden", fifo_rd_en, 0);
      @(negedge clk); #1;
      check("t2_s1_data", m_data, 8'h5A);
      check("t2_s1_last", m_last, 1);
      check("t2_s1_rden", fifo_rd_en, 0);
      @(negedge clk); #1;
      exp_wc++;
      check("t2_wcnt", word_cnt, exp_wc);
      check("t2_idle_valid", m_valid, 0);
      check("t2_idle_busy", busy, 0);
      check("t2_idle_rden", fifo_rd_en, 0);

      // 3. backpressure on the first slice with a second word waiting
      @(negedge clk);
      m_ready = 1'b0;
      push(16'hA55A);
      push(16'h1111);
      #1;
      check("t3_rden", fifo_rd_en, 1);
      @(negedge clk);
      @(negedge clk); #1;
      check("t3_s0_data", m_data, 8'hA5);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); #1;
         check("t3_hold_valid", m_valid, 1);
         check("t3_hold_data", m_data, 8'hA5);
         check("t3_hold_last", m_last, 0);
         check("t3_hold_rden", fifo_rd_en, 0);
      end
      m_ready = 1'b1;
      collect(4, 16);
      check("t3_d0", got_data[0], 8'hA5);
      check("t3_d1", got_data[1], 8'h5A);
      check("t3_d2", got_data[2], 8'h11);
      check("t3_d3", got_data[3], 8'h11);
      check("t3_rd_pulses", rd_pulses, 1);
      @(negedge clk); #1;
      exp_wc += 2;
      check("t3_wcnt", word_cnt, exp_wc);

      // table: one word each, m_ready=1
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         push(vecs[i].word);
         collect(2, 12);
         check("tbl_s0", got_data[0], vecs[i].s0);
         check("tbl_s1", got_data[1], vecs[i].s1);
         check("tbl_last0", got_last[0], 0);
         check("tbl_last1", got_last[1], 1);
`ifdef FIFO_RD_SER_PARITY_EN
         check("tbl_par0", got_par[0], ^vecs[i].s0);
         check("tbl_par1", got_par[1], ^vecs[i].s1);
`endif
         @(negedge clk); #1;
         exp_wc++;
         check("tbl_wcnt", word_cnt, exp_wc);
         check("tbl_busy", busy, 0);
      end

      // 4. three back-to-back words
      @(negedge clk);
      push(16'h1234);
      push(16'h5678);
      push(16'h9ABC);
      collect(6, 30);
      check("t4_d0", got_data[0], 8'h12);
      check("t4_d1", got_data[1], 8'h34);
      check("t4_d2", got_data[2], 8'h56);
      check("t4_d3", got_data[3], 8'h78);
      check("t4_d4", got_data[4], 8'h9A);
      check("t4_d5", got_data[5], 8'hBC);
      check("t4_rd_pulses", rd_pulses, 3);
      check("t4_in_word", got_cyc[1] - got_cyc[0], 1);
      check("t4_gap1", got_cyc[2] - got_cyc[1], 2);
      check("t4_gap2", got_cyc[4] - got_cyc[3], 2);
      @(negedge clk); #1;
      exp_wc += 3;
      check("t4_wcnt", word_cnt, exp_wc);

      // 5. reset mid-word
      @(negedge clk);
      push(16'h1234);
      collect(1, 10);
      check("t5_s0", got_data[0], 8'h12);
      @(negedge clk); #1;
      check("t5_s1_pending", m_data, 8'h34);
      rst_n = 1'b0;
      #1;
      check("t5_rst_valid", m_valid, 0);
      check("t5_rst_data", m_data, 8'h00);
      check("t5_rst_last", m_last, 0);
      check("t5_rst_wcnt", word_cnt, 0);
      check("t5_rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int seen = 0;
         for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            if (m_valid) seen++;
         end
         check("t5_no_slice", seen, 0);
      end
      check("t5_wcnt", word_cnt, 0);

      // 6. LSB-first instance
      @(negedge clk);
      fifo_empty2 = 1'b0;
      #1;
      check("t6_rden", fifo_rd_en2, 1);
      @(negedge clk);
      fifo_empty2 = 1'b1;
      #1;
      check("t6_fetch_valid", m_valid2, 0);
      @(negedge clk); #1;
      check("t6_s0_valid", m_valid2, 1);
      check("t6_s0_data", m_data2, 8'h5A);
      check("t6_s0_last", m_last2, 0);
`ifdef FIFO_RD_SER_PARITY_EN
      check("t6_s0_par", m_parity2, 0);
`endif
      @(negedge clk); #1;
      check("t6_s1_data", m_data2, 8'hA5);
      check("t6_s1_last", m_last2, 1);
      @(negedge clk); #1;
      check("t6_idle_valid", m_valid2, 0);
      check("t6_wcnt", word_cnt2, 1);
      check("t6_busy", busy2, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
